// File: rtl/snn_pkg.sv
// Shared types and default sizes for the spiking-neuron datapath.
package snn_pkg;

   localparam int NUM_PRE = 4;
   localparam int W_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_INTEGRATE = 2'd1,
      ST_REFRACT   = 2'd2
   } lif_state_e;

   // Wide enough for NUM_PRE weights of all-ones to add without overflow.
   function automatic int sum_width(input int npre, input int w);
      return w + $clog2(npre) + 1;
   endfunction

endpackage

// File: rtl/synapse_sum.sv
// Combinational weighted sum of the synapses whose presynaptic spike is set.
module synapse_sum #(
   parameter int NUM_PRE = 4,
   parameter int W_WIDTH = 4,
   parameter int SUM_W   = 7
) (
   input  logic [NUM_PRE-1:0]         pre_spike,
   input  logic [NUM_PRE*W_WIDTH-1:0] weights,
   output logic [SUM_W-1:0]           sum
);

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_PRE; i++) begin
         if (pre_spike[i]) begin
            sum = sum + SUM_W'(weights[i*W_WIDTH +: W_WIDTH]);
         end
      end
   end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: weight register, leaky membrane, threshold
// fire with a fixed refractory period and a wrapping fire counter.
module lif_neuron #(
   parameter int         NUM_PRE        = snn_pkg::NUM_PRE,
   parameter int         W_WIDTH        = snn_pkg::W_WIDTH,
   parameter logic [7:0] THRESHOLD      = 8'd64,
   parameter int         LEAK_SHIFT     = 3,
   parameter int         REFRACT_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic [NUM_PRE-1:0]         pre_spike,
   input  logic [NUM_PRE*W_WIDTH-1:0] weight_in,
   input  logic                       w_load,
   output logic                       post_spike,
   output logic [7:0]                 membrane,
   output logic                       busy,
   output logic [7:0]                 spike_count
);
   import snn_pkg::*;

   localparam int SUM_W = sum_width(NUM_PRE, W_WIDTH);

   lif_state_e                 state_q, state_d;
   logic [7:0]                 mem_q, mem_d;
   logic                       post_q, post_d;
   logic [3:0]                 refr_q, refr_d;
   logic [7:0]                 cnt_q, cnt_d;
   logic [NUM_PRE*W_WIDTH-1:0] w_q, w_d;
   logic [SUM_W-1:0]           syn_sum;
   logic [8:0]                 v_next;

   synapse_sum #(
      .NUM_PRE (NUM_PRE),
      .W_WIDTH (W_WIDTH),
      .SUM_W   (SUM_W)
   ) u_synapse_sum (
      .pre_spike (pre_spike),
      .weights   (w_q),
      .sum       (syn_sum)
   );

   always_comb begin
      // A weight load never affects the sum computed on the same edge.
      w_d     = w_load ? weight_in : w_q;
      state_d = state_q;
      mem_d   = mem_q;
      post_d  = 1'b0;
      refr_d  = refr_q;
      cnt_d   = cnt_q;
      v_next  = 9'(mem_q) - 9'(mem_q >> LEAK_SHIFT) + 9'(syn_sum);

      if (!enable) begin
         state_d = ST_IDLE;
         refr_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_INTEGRATE;
            ST_INTEGRATE: begin
               if (v_next >= {1'b0, THRESHOLD}) begin
                  post_d  = 1'b1;
                  mem_d   = '0;
                  refr_d  = 4'(REFRACT_CYCLES);
                  cnt_d   = cnt_q + 8'd1;
                  state_d = ST_REFRACT;
               end else begin
                  mem_d = v_next[7:0];
               end
            end
            ST_REFRACT: begin
               mem_d  = '0;
               refr_d = refr_q - 4'd1;
               if (refr_q == 4'd1) state_d = ST_INTEGRATE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mem_q   <= '0;
         post_q  <= 1'b0;
         refr_q  <= '0;
         cnt_q   <= '0;
         w_q     <= '0;
      end else begin
         state_q <= state_d;
         mem_q   <= mem_d;
         post_q  <= post_d;
         refr_q  <= refr_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
      end
   end

   assign post_spike  = post_q;
   assign membrane    = mem_q;
   assign busy        = (state_q == ST_REFRACT);
   assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed and randomized bench for lif_neuron against a cycle-level
// behavioural neuron model.
module tb_lif_neuron;

   localparam int THR = 64;
   localparam int LS  = 3;
   localparam int RC  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [3:0]  pre_spike = '0;
   logic [15:0] weight_in = '0;
   logic        w_load = 1'b0;
   logic        post_spike;
   logic [7:0]  membrane;
   logic        busy;
   logic [7:0]  spike_count;

   int checks = 0;
   int failures = 0;

   // Behavioural model: mode 0 = idle, 1 = integrating, 2 = refractory.
   int m_mode = 0;
   int m_mem = 0;
   int m_post = 0;
   int m_cnt = 0;
   int m_left = 0;
   int m_w[4] = '{0, 0, 0, 0};

   lif_neuron dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .pre_spike   (pre_spike),
      .weight_in   (weight_in),
      .w_load      (w_load),
      .post_spike  (post_spike),
      .membrane    (membrane),
      .busy        (busy),
      .spike_count (spike_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit en, input logic [3:0] pre,
                             input bit wl, input logic [15:0] win);
      int sum;
      int v;
      if (r) begin
         m_mode = 0; m_mem = 0; m_post = 0; m_cnt = 0; m_left = 0;
         for (int i = 0; i < 4; i++) m_w[i] = 0;
         return;
      end
      sum = 0;
      for (int i = 0; i < 4; i++) if (pre[i]) sum += m_w[i];
      m_post = 0;
      if (!en) begin
         m_mode = 0;
         m_left = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         v = m_mem - (m_mem / (1 << LS)) + sum;
         if (v >= THR) begin
            m_post = 1; m_mem = 0; m_left = RC; m_mode = 2;
            m_cnt = (m_cnt + 1) % 256;
         end else begin
            m_mem = v;
         end
      end else begin
         m_mem = 0;
         m_left--;
         if (m_left == 0) m_mode = 1;
      end
      if (wl) for (int i = 0; i < 4; i++) m_w[i] = int'(win[i*4 +: 4]);
   endtask

   task automatic step(input bit r, input bit en, input logic [3:0] pre,
                       input bit wl, input logic [15:0] win);
      rst = r; enable = en; pre_spike = pre; w_load = wl; weight_in = win;
      @(posedge clk);
      model_edge(r, en, pre, wl, win);
      #1;
      check("post_spike", 16'(post_spike), 16'(m_post));
      check("membrane", 16'(membrane), 16'(m_mem));
      check("busy", 16'(busy), 16'(m_mode == 2));
      check("spike_count", 16'(spike_count), 16'(m_cnt));
   endtask

   initial begin
      int pulses;
      int budget;
      logic [15:0] rw;

      // Reset with every other input active: reset must win.
      step(1, 1, 4'hF, 1, 16'hFFFF);
      step(1, 1, 4'hF, 1, 16'hFFFF);
      check("rst_post", 16'(post_spike), 16'd0);
      check("rst_mem", 16'(membrane), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_count", 16'(spike_count), 16'd0);

      // All-ones weights, full spike input: 60, then fire at 113.
      step(0, 0, 4'h0, 1, 16'hFFFF);
      step(0, 1, 4'hF, 0, 16'h0);
      check("idle_edge_no_integrate", 16'(membrane), 16'd0);
      step(0, 1, 4'hF, 0, 16'h0);
      check("mem60", 16'(membrane), 16'd60);
      step(0, 1, 4'hF, 0, 16'h0);
      check("fire_post", 16'(post_spike), 16'd1);
      check("fire_mem", 16'(membrane), 16'd0);
      check("fire_count", 16'(spike_count), 16'd1);
      for (int k = 0; k < RC; k++) begin
         check("refract_busy", 16'(busy), 16'd1);
         check("refract_mem", 16'(membrane), 16'd0);
         step(0, 1, 4'hF, 0, 16'h0);
         check("post_one_cycle", 16'(post_spike), 16'd0);
      end
      check("refract_over", 16'(busy), 16'd0);
      step(0, 1, 4'hF, 0, 16'h0);
      check("post_refract_mem60", 16'(membrane), 16'd60);

      // Single pulse on weight 8: 8, then leak to 7, then floor leak holds 7.
      step(1, 0, 4'h0, 0, 16'h0);
      step(0, 0, 4'h0, 1, 16'h0008);
      step(0, 1, 4'h0, 0, 16'h0);
      step(0, 1, 4'h1, 0, 16'h0);
      check("leak_mem8", 16'(membrane), 16'd8);
      step(0, 1, 4'h0, 0, 16'h0);
      check("leak_mem7", 16'(membrane), 16'd7);
      step(0, 1, 4'h0, 0, 16'h0);
      step(0, 1, 4'h0, 0, 16'h0);
      check("floor_leak_hold7", 16'(membrane), 16'd7);
      step(0, 0, 4'hF, 0, 16'h0);
      step(0, 0, 4'hF, 0, 16'h0);
      check("idle_hold7", 16'(membrane), 16'd7);

      // Drop enable in the 2nd refractory cycle.
      step(1, 0, 4'h0, 0, 16'h0);
      step(0, 0, 4'h0, 1, 16'hFFFF);
      step(0, 1, 4'hF, 0, 16'h0);
      step(0, 1, 4'hF, 0, 16'h0);
      step(0, 1, 4'hF, 0, 16'h0);
      check("drop_fire", 16'(post_spike), 16'd1);
      step(0, 1, 4'hF, 0, 16'h0);
      step(0, 0, 4'hF, 0, 16'h0);
      check("drop_busy0", 16'(busy), 16'd0);
      step(0, 1, 4'hF, 0, 16'h0);
      check("reenable_no_integrate", 16'(membrane), 16'd0);
      step(0, 1, 4'hF, 0, 16'h0);
      check("reenable_mem60", 16'(membrane), 16'd60);

      // Weight load on the firing edge: old weights still fire.
      step(0, 1, 4'hF, 1, 16'h0000);
      check("wload_old_fire", 16'(post_spike), 16'd1);
      for (int k = 0; k < RC + 1; k++) step(0, 1, 4'hF, 0, 16'h0);
      check("wload_new_zero", 16'(membrane), 16'd0);

      // 256 fires from reset: counter wraps to 0.
      step(1, 0, 4'h0, 0, 16'h0);
      step(0, 0, 4'h0, 1, 16'hFFFF);
      pulses = 0;
      budget = 256 * 8;
      while (pulses < 256 && budget > 0) begin
         step(0, 1, 4'hF, 0, 16'h0);
         if (post_spike === 1'b1) pulses++;
         budget--;
      end
      check("wrap_fires", 16'(pulses), 16'd256);
      check("wrap_count", 16'(spike_count), 16'd0);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         rw = 16'($urandom);
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
              4'($urandom), ($urandom_range(0, 15) == 0), rw);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
